// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer: external-memory bus-cycle engine.
// Runs one read or write access through the ADDR -> SETUP -> DATA -> HOLD
// sequence and drives the memory strobes and the SysBus enables. The address
// and minimum data phase lengths are set by parameters. nWait can stretch the
// data phase, up to MAX_WAIT extra cycles, before the access is forced to end
// with an error. A request seen in HOLD chains straight into the next access.
module mem_bus_sequencer #(
  parameter int ADDR_CYCLES = 1,
  parameter int WAIT_CYCLES = 1,
  parameter int MAX_WAIT    = 15,
  parameter int CNT_W       = 4
) (
  input  logic Clock,
  input  logic nReset,
  input  logic Req,
  input  logic Write,
  input  logic nWait,
  output logic Busy,
  output logic Done,
  output logic Err,
  output logic AddrEn,
  output logic DataOutEn,
  output logic DataLatch,
  output logic ALE,
  output logic nME,
  output logic nOE,
  output logic nWE,
  output logic ENB
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    SETUP = 3'd2,
    DATA  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXT_LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_next;
  logic             write_q;
  logic             write_next;
  logic             timeout_q;
  logic             timeout_next;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] phase_next;
  logic [CNT_W-1:0] ext_cnt;
  logic [CNT_W-1:0] ext_next;
  logic             min_done;
  logic             ext_full;

  // Data-phase status: the minimum length has elapsed, and the extension budget is used up.
  always_comb begin
    min_done = (phase_cnt == WAIT_LAST);
    ext_full = (ext_cnt == EXT_LIMIT);
  end

  // State, latched direction, timeout flag and counters; reset drops everything to idle at once.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      timeout_q <= 1'b0;
      phase_cnt <= '0;
      ext_cnt   <= '0;
    end else begin
      state     <= state_next;
      write_q   <= write_next;
      timeout_q <= timeout_next;
      phase_cnt <= phase_next;
      ext_cnt   <= ext_next;
    end
  end

  // Next-state and counter update, plus the decode of state and latched Write into the bus controls.
  always_comb begin
    state_next   = state;
    write_next   = write_q;
    timeout_next = timeout_q;
    phase_next   = phase_cnt;
    ext_next     = ext_cnt;

    Busy      = 1'b0;
    Done      = 1'b0;
    Err       = 1'b0;
    AddrEn    = 1'b0;
    DataOutEn = 1'b0;
    DataLatch = 1'b0;
    ALE       = 1'b0;
    nME       = 1'b1;
    nOE       = 1'b1;
    nWE       = 1'b1;
    ENB       = 1'b0;

    case (state)
      IDLE: begin
        if (Req) begin
          state_next   = ADDR;
          write_next   = Write;
          timeout_next = 1'b0;
          phase_next   = '0;
          ext_next     = '0;
        end
      end

      ADDR: begin
        Busy   = 1'b1;
        ALE    = 1'b1;
        AddrEn = 1'b1;
        if (phase_cnt == ADDR_LAST) begin
          state_next = SETUP;
          phase_next = '0;
        end else if (phase_cnt != CNT_FULL) begin
          phase_next = phase_cnt + CNT_ONE;
        end
      end

      SETUP: begin
        Busy       = 1'b1;
        nME        = 1'b0;
        DataOutEn  = write_q;
        state_next = DATA;
        phase_next = '0;
        ext_next   = '0;
      end

      DATA: begin
        Busy      = 1'b1;
        nME       = 1'b0;
        ENB       = 1'b1;
        nOE       = write_q;
        nWE       = ~write_q;
        DataOutEn = write_q;
        DataLatch = ~write_q & min_done & ~ext_full & nWait;
        if (!min_done) begin
          if (phase_cnt != CNT_FULL) begin
            phase_next = phase_cnt + CNT_ONE;
          end
        end else if (ext_full) begin
          state_next   = HOLD;
          timeout_next = 1'b1;
        end else if (nWait) begin
          state_next   = HOLD;
          timeout_next = 1'b0;
        end else if (ext_cnt != CNT_FULL) begin
          ext_next = ext_cnt + CNT_ONE;
        end
      end

      HOLD: begin
        Busy      = 1'b1;
        Done      = 1'b1;
        Err       = timeout_q;
        nME       = 1'b0;
        DataOutEn = write_q;
        if (Req) begin
          state_next   = ADDR;
          write_next   = Write;
          timeout_next = 1'b0;
          phase_next   = '0;
          ext_next     = '0;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
